// File: rtl/mips32_pipe_fwd.sv
// mips32_pipe_fwd: 5-stage IF/ID/EX/MEM/WB integer pipeline, unified word memory.
// Ports: clk, rst (sync, active high), halted, pc (fetch word address), retire_cnt.
// Build option: define FORWARD_EN for EX/MEM and MEM/WB operand bypass;
// without it, ID interlocks on any pending producer in EX or MEM.
module mips32_pipe_fwd #(
    parameter int MEM_DEPTH = 1024,
    parameter int RESET_PC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        halted,
    output logic [31:0] pc,
    output logic [31:0] retire_cnt
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] alu;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        hlt;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] res;
    } mem_wb_t;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_DEPTH-1];

    if_id_t  if_id;
    id_ex_t  id_ex;
    id_ex_t  id_next;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;
    logic    hlt_seen;

    // ---------------- ID decode ----------------
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr;
    logic [4:0]  id_dest;
    logic        id_is_rr;
    logic        id_is_ri;
    logic        id_is_br;
    logic        id_hlt;
    logic [31:0] id_a;
    logic [31:0] id_b;
    logic        wb_we;

    assign id_op  = if_id.ir[31:26];
    assign id_rs  = if_id.ir[25:21];
    assign id_rt  = if_id.ir[20:16];
    assign id_rd  = if_id.ir[15:11];
    assign id_imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};

    assign id_is_rr = (id_op <= OP_MUL);
    assign id_is_ri = (id_op == OP_ADDI) || (id_op == OP_SUBI) ||
                      (id_op == OP_SLTI) || (id_op == OP_LW);
    assign id_is_br = (id_op == OP_BNEQZ) || (id_op == OP_BEQZ);
    assign id_hlt   = if_id.valid && (id_op == OP_HLT);

    always_comb begin
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        id_wr     = 1'b0;
        id_dest   = 5'd0;
        unique case (1'b1)
            id_is_rr: begin
                id_use_rs = 1'b1;
                id_use_rt = 1'b1;
                id_wr     = 1'b1;
                id_dest   = id_rd;
            end
            id_is_ri: begin
                id_use_rs = 1'b1;
                id_wr     = 1'b1;
                id_dest   = id_rt;
            end
            (id_op == OP_SW): begin
                id_use_rs = 1'b1;
                id_use_rt = 1'b1;
            end
            id_is_br: begin
                id_use_rs = 1'b1;
            end
            default: ;
        endcase
    end

    // WB result is bypassed into the ID read in the same cycle.
    assign wb_we = mem_wb.valid && mem_wb.wr &&
                   (mem_wb.dest != 5'd0) && !halted;

    always_comb begin
        if (id_rs == 5'd0)
            id_a = 32'd0;
        else if (wb_we && (mem_wb.dest == id_rs))
            id_a = mem_wb.res;
        else
            id_a = Reg[id_rs];
        if (id_rt == 5'd0)
            id_b = 32'd0;
        else if (wb_we && (mem_wb.dest == id_rt))
            id_b = mem_wb.res;
        else
            id_b = Reg[id_rt];
    end

    always_comb begin
        id_next       = '0;
        id_next.valid = if_id.valid;
        id_next.op    = id_op;
        id_next.rs    = id_rs;
        id_next.rt    = id_rt;
        id_next.dest  = id_dest;
        id_next.wr    = id_wr;
        id_next.a     = id_a;
        id_next.b     = id_b;
        id_next.imm   = id_imm;
        id_next.npc   = if_id.npc;
    end

    // ---------------- hazards ----------------
    logic load_use;
    logic stall;

    assign load_use = if_id.valid && id_ex.valid &&
                      (id_ex.op == OP_LW) && (id_ex.dest != 5'd0) &&
                      ((id_use_rs && (id_rs == id_ex.dest)) ||
                       (id_use_rt && (id_rt == id_ex.dest)));

`ifdef FORWARD_EN
    assign stall = load_use;
`else
    logic raw_ex;
    logic raw_mem;

    assign raw_ex = if_id.valid && id_ex.valid && id_ex.wr &&
                    (id_ex.dest != 5'd0) &&
                    ((id_use_rs && (id_rs == id_ex.dest)) ||
                     (id_use_rt && (id_rt == id_ex.dest)));
    assign raw_mem = if_id.valid && ex_mem.valid && ex_mem.wr &&
                     (ex_mem.dest != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_mem.dest)) ||
                      (id_use_rt && (id_rt == ex_mem.dest)));
    assign stall = load_use || raw_ex || raw_mem;
`endif

    // ---------------- EX ----------------
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_alu;
    logic        ex_taken;
    logic [31:0] ex_target;

`ifdef FORWARD_EN
    // EX/MEM never holds a load here: the load-use stall keeps it one
    // stage further back, so its ALU field is always a register result.
    always_comb begin
        ex_a = id_ex.a;
        ex_b = id_ex.b;
        if (ex_mem.valid && ex_mem.wr && (ex_mem.dest != 5'd0) &&
            (ex_mem.dest == id_ex.rs))
            ex_a = ex_mem.alu;
        else if (mem_wb.valid && mem_wb.wr && (mem_wb.dest != 5'd0) &&
                 (mem_wb.dest == id_ex.rs))
            ex_a = mem_wb.res;
        if (ex_mem.valid && ex_mem.wr && (ex_mem.dest != 5'd0) &&
            (ex_mem.dest == id_ex.rt))
            ex_b = ex_mem.alu;
        else if (mem_wb.valid && mem_wb.wr && (mem_wb.dest != 5'd0) &&
                 (mem_wb.dest == id_ex.rt))
            ex_b = mem_wb.res;
    end
`else
    assign ex_a = id_ex.a;
    assign ex_b = id_ex.b;
`endif

    always_comb begin
        ex_alu = 32'd0;
        case (id_ex.op)
            OP_ADD:  ex_alu = ex_a + ex_b;
            OP_SUB:  ex_alu = ex_a - ex_b;
            OP_AND:  ex_alu = ex_a & ex_b;
            OP_OR:   ex_alu = ex_a | ex_b;
            OP_SLT:  ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
            OP_MUL:  ex_alu = ex_a * ex_b;
            OP_ADDI: ex_alu = ex_a + id_ex.imm;
            OP_LW:   ex_alu = ex_a + id_ex.imm;
            OP_SW:   ex_alu = ex_a + id_ex.imm;
            OP_SUBI: ex_alu = ex_a - id_ex.imm;
            OP_SLTI: ex_alu = {31'd0, $signed(ex_a) < $signed(id_ex.imm)};
            default: ex_alu = 32'd0;
        endcase
    end

    assign ex_taken = id_ex.valid &&
                      (((id_ex.op == OP_BEQZ) && (ex_a == 32'd0)) ||
                       ((id_ex.op == OP_BNEQZ) && (ex_a != 32'd0)));
    assign ex_target = id_ex.npc + id_ex.imm;

    // ---------------- MEM ----------------
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_res;
    logic          mem_we;

    assign mem_addr = ex_mem.alu[AW-1:0];
    assign mem_res  = (ex_mem.op == OP_LW) ? Mem[mem_addr] : ex_mem.alu;
    assign mem_we   = ex_mem.valid && (ex_mem.op == OP_SW) && !halted;

    // ---------------- IF ----------------
    logic fetch_en;

    // HLT in ID, or any HLT already past ID, freezes fetch.
    assign fetch_en = !stall && !id_hlt && !hlt_seen && !halted;

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= 32'(RESET_PC);
            if_id      <= '0;
            id_ex      <= '0;
            ex_mem     <= '0;
            mem_wb     <= '0;
            halted     <= 1'b0;
            retire_cnt <= 32'd0;
            hlt_seen   <= 1'b0;
        end else begin
            if (ex_taken) begin
                pc    <= ex_target;
                if_id <= '0;
            end else if (stall) begin
                pc    <= pc;
            end else if (fetch_en) begin
                pc        <= pc + 32'd1;
                if_id.valid <= 1'b1;
                if_id.ir    <= Mem[pc[AW-1:0]];
                if_id.npc   <= pc + 32'd1;
            end else begin
                if_id <= '0;
            end

            if (ex_taken || stall || !if_id.valid)
                id_ex <= '0;
            else
                id_ex <= id_next;

            if (id_hlt && !ex_taken)
                hlt_seen <= 1'b1;

            ex_mem.valid <= id_ex.valid;
            ex_mem.op    <= id_ex.op;
            ex_mem.dest  <= id_ex.dest;
            ex_mem.wr    <= id_ex.wr;
            ex_mem.alu   <= ex_alu;
            ex_mem.b     <= ex_b;

            mem_wb.valid <= ex_mem.valid;
            mem_wb.hlt   <= ex_mem.valid && (ex_mem.op == OP_HLT);
            mem_wb.dest  <= ex_mem.dest;
            mem_wb.wr    <= ex_mem.wr;
            mem_wb.res   <= mem_res;

            if (mem_wb.valid) begin
                retire_cnt <= retire_cnt + 32'd1;
                if (mem_wb.hlt)
                    halted <= 1'b1;
            end
        end
    end

    // Architectural writes; suppressed during reset so in-flight work dies.
    always_ff @(posedge clk) begin
        if (!rst && wb_we)
            Reg[mem_wb.dest] <= mem_wb.res;
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            Mem[mem_addr] <= ex_mem.b;
    end

endmodule

// File: tb/tb_mips32_pipe_fwd.sv
// tb_mips32_pipe_fwd: scenario tasks for mips32_pipe_fwd with a result queue.
// Expected register/memory values are queued per program and drained after halt.
module tb_mips32_pipe_fwd;

    logic        clk;
    logic        rst;
    logic        halted;
    logic [31:0] pc;
    logic [31:0] retire_cnt;

    mips32_pipe_fwd #(
        .MEM_DEPTH(1024),
        .RESET_PC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .halted    (halted),
        .pc        (pc),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FORWARD_EN
    localparam int CYC_028 = 10;
    localparam int CYC_029 = 9;
`else
    localparam int CYC_028 = 13;
    localparam int CYC_029 = 12;
`endif

    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001;
    localparam logic [5:0] AND_ = 6'b000010, OR_ = 6'b000011;
    localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101;
    localparam logic [5:0] LW = 6'b001000, SW = 6'b001001;
    localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011;
    localparam logic [5:0] SLTI = 6'b001100, BNEQZ = 6'b001101;
    localparam logic [5:0] BEQZ = 6'b001110, HLT = 6'b111111;

    typedef struct {
        bit          is_mem;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] prog[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] rr(input logic [5:0] op,
                                       input int rd, input int rs,
                                       input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op,
                                       input int rt, input int rs,
                                       input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic exp_reg(input int r, input logic [31:0] v,
                           input string n);
        sbq.push_back('{1'b0, r, v, n});
    endtask

    task automatic exp_mem(input int a, input logic [31:0] v,
                           input string n);
        sbq.push_back('{1'b1, a, v, n});
    endtask

    // Hold reset, wipe low memory and registers, load prog.
    task automatic boot();
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++) dut.Mem[i] <= 32'd0;
        for (int i = 0; i < 32; i++) dut.Reg[i] <= 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] <= prog[i];
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
            if (halted) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc !== 32'd0) begin
            bad++;
            $display("FAIL reset_pc: got %0d want 0", pc);
        end
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_halted: got %b want 0", halted);
        end
        total++;
        if (retire_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_retire: got %0d want 0", retire_cnt);
        end
    endtask

    task automatic test_fwd_chain();
        exp_t e;
        logic [31:0] got;
        int cyc;
        prog = '{ri(ADDI, 1, 0, 10), ri(ADDI, 2, 0, 20),
                 ri(ADDI, 3, 0, 25), rr(ADD, 4, 1, 2),
                 rr(ADD, 5, 4, 3), {HLT, 26'd0}};
        boot();
        exp_reg(1, 32'd10, "chain_r1");
        exp_reg(2, 32'd20, "chain_r2");
        exp_reg(3, 32'd25, "chain_r3");
        exp_reg(4, 32'd30, "chain_r4");
        exp_reg(5, 32'd55, "chain_r5");
        go();
        run_halt(cyc);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL chain_halt: halted=%b want 1", halted);
        end
        total++;
        if (cyc !== CYC_028) begin
            bad++;
            $display("FAIL chain_cycles: got %0d want %0d", cyc, CYC_028);
        end
        total++;
        if (retire_cnt !== 32'd6) begin
            bad++;
            $display("FAIL chain_retire: got %0d want 6", retire_cnt);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [31:0] got;
        int cyc;
        prog = '{ri(LW, 2, 1, 0), ri(ADDI, 2, 2, 45),
                 ri(SW, 2, 1, 1), {HLT, 26'd0}};
        boot();
        dut.Reg[1] <= 32'd120;
        dut.Mem[120] <= 32'd85;
        exp_reg(2, 32'd130, "lu_r2");
        exp_mem(121, 32'd130, "lu_mem121");
        exp_mem(120, 32'd85, "lu_mem120");
        go();
        run_halt(cyc);
        total++;
        if (cyc !== CYC_029) begin
            bad++;
            $display("FAIL lu_cycles: got %0d want %0d", cyc, CYC_029);
        end
        total++;
        if (retire_cnt !== 32'd4) begin
            bad++;
            $display("FAIL lu_retire: got %0d want 4", retire_cnt);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_branch_loop();
        exp_t e;
        logic [31:0] got;
        int cyc;
        prog = '{ri(LW, 2, 10, 0), ri(ADDI, 3, 0, 1),
                 rr(MUL, 3, 3, 2), ri(SUBI, 2, 2, 1),
                 ri(BNEQZ, 0, 2, -3), ri(SW, 3, 10, -2),
                 {HLT, 26'd0}};
        boot();
        dut.Reg[10] <= 32'd200;
        dut.Mem[200] <= 32'd7;
        exp_mem(198, 32'd5040, "fact_mem198");
        exp_reg(3, 32'd5040, "fact_r3");
        exp_reg(2, 32'd0, "fact_r2");
        go();
        run_halt(cyc);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL fact_halt: halted=%b want 1", halted);
        end
        // 2 setup + 7 x 3 loop body + SW + HLT
        total++;
        if (retire_cnt !== 32'd25) begin
            bad++;
            $display("FAIL fact_retire: got %0d want 25", retire_cnt);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_r0();
        exp_t e;
        logic [31:0] got;
        int cyc;
        prog = '{ri(ADDI, 0, 0, 5), rr(ADD, 6, 0, 0), {HLT, 26'd0}};
        boot();
        dut.Reg[0] <= 32'hdeadbeef;
        dut.Reg[6] <= 32'd77;
        exp_reg(6, 32'd0, "r0_r6");
        exp_reg(0, 32'hdeadbeef, "r0_unwritten");
        go();
        run_halt(cyc);
        total++;
        if (retire_cnt !== 32'd3) begin
            bad++;
            $display("FAIL r0_retire: got %0d want 3", retire_cnt);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] got;
        int cyc;
        int w;
        prog = '{ri(ADDI, 1, 0, 10), ri(ADDI, 2, 0, 20),
                 ri(ADDI, 3, 0, 25), rr(ADD, 4, 1, 2),
                 rr(ADD, 5, 4, 3), {HLT, 26'd0}};
        boot();
        go();
        w = 0;
        while (w < 100 && dut.Reg[4] !== 32'd30) begin
            @(posedge clk);
            #1;
            w++;
        end
        total++;
        if (dut.Reg[4] !== 32'd30) begin
            bad++;
            $display("FAIL mid_wait_r4: got %0d want 30", dut.Reg[4]);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (pc !== 32'd0 || halted !== 1'b0 || retire_cnt !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: pc=%0d halted=%b retire=%0d want 0/0/0",
                     pc, halted, retire_cnt);
        end
        exp_reg(4, 32'd30, "mid_r4");
        exp_reg(5, 32'd55, "mid_r5");
        run_halt(cyc);
        total++;
        if (cyc !== CYC_028 || retire_cnt !== 32'd6) begin
            bad++;
            $display("FAIL mid_rerun: cycles=%0d retire=%0d want %0d/6",
                     cyc, retire_cnt, CYC_028);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_beqz_skip();
        exp_t e;
        logic [31:0] got;
        int cyc;
        prog = '{ri(BEQZ, 0, 0, 1), {HLT, 26'd0},
                 ri(ADDI, 7, 0, 1), {HLT, 26'd0}};
        boot();
        exp_reg(7, 32'd1, "beqz_r7");
        go();
        run_halt(cyc);
        total++;
        if (retire_cnt !== 32'd3) begin
            bad++;
            $display("FAIL beqz_retire: got %0d want 3", retire_cnt);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_alu_mix();
        exp_t e;
        logic [31:0] got;
        logic [31:0] rc;
        int cyc;
        prog = '{ri(ADDI, 1, 0, -5), ri(ADDI, 2, 0, 12),
                 rr(SUB, 3, 2, 1), rr(AND_, 4, 1, 2),
                 rr(OR_, 5, 1, 2), rr(SLT, 6, 1, 2),
                 ri(SLTI, 7, 2, -1), ri(SUBI, 8, 2, 20),
                 rr(6'b010000, 9, 1, 2), rr(MUL, 9, 1, 2),
                 ri(SW, 2, 0, -1), {HLT, 26'd0}};
        boot();
        dut.Mem[1023] <= 32'd0;
        dut.Reg[7] <= 32'd99;
        exp_reg(1, 32'hfffffffb, "alu_addi_neg");
        exp_reg(3, 32'd17, "alu_sub");
        exp_reg(4, 32'd8, "alu_and");
        exp_reg(5, 32'hffffffff, "alu_or");
        exp_reg(6, 32'd1, "alu_slt");
        exp_reg(7, 32'd0, "alu_slti");
        exp_reg(8, 32'hfffffff8, "alu_subi");
        exp_reg(9, 32'hffffffc4, "alu_mul");
        exp_mem(1023, 32'd12, "alu_sw_wrap");
        go();
        run_halt(cyc);
        total++;
        if (retire_cnt !== 32'd12) begin
            bad++;
            $display("FAIL alu_retire: got %0d want 12", retire_cnt);
        end
        rc = retire_cnt;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (halted !== 1'b1 || retire_cnt !== rc) begin
            bad++;
            $display("FAIL alu_hold: halted=%b retire=%0d want 1/%0d",
                     halted, retire_cnt, rc);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            total++;
            if (got !== e.val) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_fwd_chain();
        test_load_use();
        test_branch_loop();
        test_r0();
        test_reset_mid();
        test_beqz_skip();
        test_alu_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips32_pipe_fwd.md
MIPS32_PIPE_FWD -- requirements
Module: mips32_pipe_fwd

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, meaning words in unified instruction/data memory Mem (power of two).
REQ-002 SHALL have parameter RESET_PC, default 0, meaning word address fetched first after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port halted, output, 1, high once HLT has retired.
REQ-006 SHALL have port pc, output, 32, current fetch word address.
REQ-007 SHALL have port retire_cnt, output, 32, count of instructions reaching WB.
REQ-008 SHALL expose internal arrays Reg[0:31] (32-bit) and Mem[0:MEM_DEPTH-1] (32-bit) under exactly these names for bench preload and inspection.

Function
REQ-009 SHALL implement a single-clock 5-stage pipeline IF, ID, EX, MEM, WB with a valid bit per stage; PC is word addressed, PC+1 per fetch.
REQ-010 SHALL decode opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to 32 bits.
REQ-011 SHALL support RR ops writing rd: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101 (low 32 bits).
REQ-012 SHALL support RI ops writing rt: ADDI 001010, SUBI 001011, SLTI 001100 (signed compare); LW 001000 rt<=Mem[rs+imm]; SW 001001 Mem[rs+imm]<=rt.
REQ-013 SHALL take memory address as low log2(MEM_DEPTH) bits of rs+imm (wrap-around, no fault).
REQ-014 SHALL support BNEQZ 001101 and BEQZ 001110: compare rs to zero in EX; target = (PC of branch + 1) + imm.
REQ-015 On a taken branch SHALL load target into PC next edge and squash the instructions in IF/ID and ID/EX (2-cycle penalty); not-taken costs 0 cycles.
REQ-016 SHALL treat undefined opcodes as NOPs: they retire and increment retire_cnt but write nothing.
REQ-017 Writes to Reg[0] SHALL be discarded; reads of R0 SHALL return 0 regardless of array contents.
REQ-018 Register file SHALL bypass a same-cycle WB write to an ID read of the same register.
REQ-019 SHALL detect load-use hazard (LW in EX, dependent rs/rt in ID) and stall IF/ID one cycle, inserting a bubble into EX, in all configurations.
REQ-020 HLT 111111 in ID SHALL stop further fetch (PC frozen, IF bubbles) unless squashed by a taken branch in EX, after which fetch resumes at target.
REQ-021 When HLT reaches WB, halted SHALL rise at that edge and remain high until rst; no Reg/Mem write occurs afterwards.
REQ-022 retire_cnt SHALL increment by 1 per valid instruction (including HLT) reaching WB and wrap from 2^32-1 to 0.

Reset
REQ-023 While rst is high at a rising edge: pc<=RESET_PC, all stage valid bits<=0, halted<=0, retire_cnt<=0.
REQ-024 Reset SHALL NOT clear Reg or Mem; an in-flight SW or register write in the reset cycle SHALL be suppressed.
REQ-025 Reset asserted mid-program or after halt SHALL discard all in-flight instructions; fetch from RESET_PC begins on the first edge with rst low.

Configuration
REQ-026 Macro FORWARD_EN defined: EX operands SHALL be forwarded from EX/MEM (ALU result) and MEM/WB (ALU or load data), EX/MEM taking priority; only REQ-019 stalls occur.
REQ-027 Macro FORWARD_EN undefined: no forwarding paths; ID SHALL stall while any rs/rt source (non-R0) matches the destination of a valid writing instruction in EX or MEM (max 2 stall cycles); results SHALL be identical, only timing differs.

Verification
REQ-028 ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; ADD R4,R1,R2; ADD R5,R4,R3; HLT, no padding -> R4=30, R5=55, retire_cnt=6, both configs; halted rises exactly 3 cycles later without FORWARD_EN.
REQ-029 R1=120, Mem[120]=85; LW R2,0(R1); ADDI R2,R2,45; SW R2,1(R1); HLT -> Mem[121]=130, one load-use stall observed with FORWARD_EN.
REQ-030 Factorial loop: Mem[200]=7, R10=200, result loop using MUL/SUBI/BNEQZ, SW to Mem[198] -> Mem[198]=5040; two instructions after each taken BNEQZ never retire.
REQ-031 ADDI R0,R0,5; ADD R6,R0,R0; HLT -> R0 reads 0, R6=0.
REQ-032 rst pulsed for 1 cycle mid-run of REQ-028 program after R4 written -> pc=0, halted=0, retire_cnt=0, rerun ends with same register values.
REQ-033 BEQZ with rs=0 jumping over HLT to ADDI R7,R0,1; HLT -> R7=1, retire_cnt counts BEQZ, ADDI, HLT only.
